exhaustive_equiv_checker: RTL and testbench
===========================================

// Module: exhaustive_equiv_checker
// PURPOSE
//   Self-running stimulus engine and equivalence checker for two combinational circuits.
//   - Walks every one of the 2^N_IN input vectors on a shared bus.
//   - Compares the two circuits' responses for each vector.
//   - Reports a pass/fail verdict, a mismatch count and the first failing vector.
//   - Sits between a lab top level (switches/LEDs or sim driver) and two DUT instances.
//   - Replaces hand-written per-vector stimulus lists with a synthesizable sequencer.
// PARAMETERS
//   N_IN    3  width of the input vector applied to both circuits (1..16)
//   N_OUT   1  width of each circuit's response (1..32)
//   SETTLE  1  wait cycles after driving a vector before sampling responses (>=1)
// PORTS
//   clk             in   1        rising-edge clock
//   rst             in   1        asynchronous, active-high reset
//   start           in   1        begin a sweep; sampled only in IDLE
//   vec_out         out  N_IN     stimulus vector; drives both circuits
//   resp_a          in   N_OUT    response of circuit A
//   resp_b          in   N_OUT    response of circuit B
//   busy            out  1        high from accepted start until the sweep ends
//   done            out  1        one-cycle pulse when the sweep ends
//   pass            out  1        1 = no mismatch in last completed sweep; held until next start
//   mismatch_cnt    out  N_IN+1   number of mismatching vectors in current/last sweep
//   fail_valid      out  1        first_fail_vec holds a captured vector
//   first_fail_vec  out  N_IN     lowest-index vector where resp_a != resp_b
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, vec_out=0, busy=0, done=0, pass=0,
//     mismatch_cnt=0, fail_valid=0, first_fail_vec=0, settle counter=0.
//   - FSM states: IDLE, WAIT, CHECK, FIN.
//   - IDLE, start=1 at edge E0:
//     - vec_out<=0, busy<=1, mismatch_cnt<=0, fail_valid<=0, pass<=0.
//     - Settle counter<=SETTLE-1; go to WAIT.
//   - WAIT: decrement the settle counter each cycle; at 0 go to CHECK.
//   - CHECK (one cycle): compare resp_a vs resp_b, full N_OUT width, bitwise.
//     - On mismatch: mismatch_cnt+1. If fail_valid=0, capture vec_out into
//       first_fail_vec and set fail_valid=1.
//     - If vec_out != all-ones: vec_out+1, reload settle counter, go to WAIT.
//     - Else go to FIN.
//   - Timing: each vector is held exactly SETTLE+1 cycles.
//     The last compare occurs on edge E0 + 2^N_IN*(SETTLE+1).
//   - FIN (one cycle): done=1, busy=0, pass=(mismatch_cnt==0); return to IDLE.
//     vec_out holds the last applied vector.
//   - start while busy: ignored; the sweep is neither restarted nor extended.
//   - start held high in FIN/IDLE: a new sweep begins on the first IDLE edge with start=1.
//   - Width rules:
//     - mismatch_cnt is N_IN+1 bits, so 2^N_IN fits without saturation.
//     - The vector counter must not wrap; sweep termination is by the all-ones compare.
//   - Reset mid-sweep: the sweep is aborted, all outputs clear, no done pulse.
// CONFIGURATION
//   STOP_ON_FAIL_EN
//     - Defined: the first mismatch in CHECK goes straight to FIN.
//       mismatch_cnt=1, vec_out holds the failing vector, pass=0.
//     - Undefined: the full sweep always runs and all mismatches are counted.
// TESTING
//   1 N_IN=3, SETTLE=1, resp_b=resp_a=f(vec) -> done pulse 16 cycles after start edge;
//     pass=1, mismatch_cnt=0, fail_valid=0, vec_out=7.
//   2 resp_b differs from resp_a only at vec=5 and vec=6 -> pass=0, mismatch_cnt=2,
//     fail_valid=1, first_fail_vec=5.
//   3 STOP_ON_FAIL_EN, same as test 2 -> done 12 cycles after start; vec_out=5, mismatch_cnt=1.
//   4 resp_b=~resp_a, N_IN=4, SETTLE=3 -> mismatch_cnt=16 (no overflow), first_fail_vec=0,
//     done 64 cycles after start.
//   5 start pulsed again at cycle 5 of a sweep -> ignored; done still at cycle 16, one pulse only.
//   6 rst asserted mid-sweep (vec_out=3) -> same cycle: busy=0, vec_out=0, counts clear;
//     a new start after release completes normally as in test 1.

Source files
------------

// File: rtl/exhaustive_equiv_checker.sv
// exhaustive_equiv_checker
// Walks all 2^N_IN input vectors on a shared stimulus bus and compares the
// responses of two combinational circuits. It reports a pass/fail verdict,
// the number of mismatching vectors and the lowest-index failing vector.
// Each vector is held for SETTLE wait cycles plus one compare cycle.
// Optional build macro: STOP_ON_FAIL_EN (end the sweep on the first mismatch).
module exhaustive_equiv_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  resp_a,
  input  logic [N_OUT-1:0]  resp_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // The settle counter only ever holds values 0..SETTLE-1.
  localparam int              SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE - 1);
  // The sweep ends by comparing against the last vector, so the counter never wraps.
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN:0]    cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic [N_IN-1:0]  first_q, first_d;

  logic             mis;
  logic             sweep_end;
  logic [N_IN:0]    cnt_next;

  // Full-width bitwise comparison of the two responses.
  assign mis = (resp_a != resp_b);

  // Next-state logic for the sweep sequencer and its result registers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    first_d   = first_q;
    cnt_next  = cnt_q + (N_IN+1)'(mis);
    sweep_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d    = '0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          fv_d     = 1'b0;
          pass_d   = 1'b0;
          settle_d = SETTLE_INIT;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      S_CHECK: begin
        cnt_d = cnt_next;
        if (mis && !fv_q) begin
          first_d = vec_q;
          fv_d    = 1'b1;
        end
`ifdef STOP_ON_FAIL_EN
        sweep_end = (vec_q == VEC_LAST) || mis;
`else
        sweep_end = (vec_q == VEC_LAST);
`endif
        if (sweep_end) begin
          // Verdict and done are registered on the final compare edge so they
          // are visible during the single FIN cycle.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (cnt_next == '0);
          state_d = S_FIN;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          settle_d = SETTLE_INIT;
          state_d  = S_WAIT;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      first_q  <= first_d;
    end
  end

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_cnt   = cnt_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = first_q;

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Testbench for exhaustive_equiv_checker.
// Two instances: N_IN=3/N_OUT=2/SETTLE=1 and N_IN=4/N_OUT=1/SETTLE=3.
// Circuit A is a fixed function of the vector; circuit B is A with faults
// injected according to the selected mode.
module tb_exhaustive_equiv_checker;

  localparam int BUDGET = 100;

  logic clk = 1'b0;
  logic rst;
  logic start3, start4;

  logic [2:0] vec3;
  logic [1:0] resp_a3, resp_b3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] cnt3;
  logic [2:0] first3;

  logic [3:0] vec4;
  logic       resp_a4, resp_b4;
  logic       busy4, done4, pass4, fv4;
  logic [4:0] cnt4;
  logic [3:0] first4;

  // 0: equal, 1: bit1 flipped at vec 5 and bit0 at vec 6, 2: inverted, 3: bit0 flipped at last vector
  int mode;
  int sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exhaustive_equiv_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec_out(vec3),
    .resp_a(resp_a3), .resp_b(resp_b3), .busy(busy3), .done(done3),
    .pass(pass3), .mismatch_cnt(cnt3), .fail_valid(fv3), .first_fail_vec(first3)
  );

  exhaustive_equiv_checker #(.N_IN(4), .N_OUT(1), .SETTLE(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .vec_out(vec4),
    .resp_a(resp_a4), .resp_b(resp_b4), .busy(busy4), .done(done4),
    .pass(pass4), .mismatch_cnt(cnt4), .fail_valid(fv4), .first_fail_vec(first4)
  );

  // Reference circuits and fault injection.
  always_comb begin
    resp_a3 = {vec3[0] ^ vec3[2], vec3[1] & vec3[2]};
    resp_b3 = resp_a3;
    case (mode)
      1: begin
        if (vec3 == 3'd5) resp_b3 = resp_a3 ^ 2'b10;
        if (vec3 == 3'd6) resp_b3 = resp_a3 ^ 2'b01;
      end
      2: resp_b3 = ~resp_a3;
      3: if (vec3 == 3'd7) resp_b3 = resp_a3 ^ 2'b01;
      default: resp_b3 = resp_a3;
    endcase
    resp_a4 = ^vec4;
    resp_b4 = (mode == 2) ? ~resp_a4 : resp_a4;
  end

  // Observed outputs of the instance under test, zero-extended.
  logic        s_busy, s_done, s_pass, s_fv;
  logic [31:0] s_cnt, s_first, s_vec;
  always_comb begin
    if (sel == 4) begin
      s_busy = busy4; s_done = done4; s_pass = pass4; s_fv = fv4;
      s_cnt = 32'(cnt4); s_first = 32'(first4); s_vec = 32'(vec4);
    end else begin
      s_busy = busy3; s_done = done3; s_pass = pass3; s_fv = fv3;
      s_cnt = 32'(cnt3); s_first = 32'(first3); s_vec = 32'(vec3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one complete sweep, optionally pulsing start again at cycle restart_at.
  task automatic run_sweep(input string tag, input int dut, input int m,
                           input logic e_pass, input int e_cnt, input logic e_fv,
                           input int e_first, input int e_vec, input int e_lat,
                           input int restart_at);
    int lat;
    int pulses;
    sel  = dut;
    mode = m;
    lat  = 0;
    pulses = 0;
    @(negedge clk);
    if (dut == 4) start4 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    start4 = 1'b0;
    check({tag, " busy_after_start"}, 32'(s_busy), 32'd1);
    for (int k = 1; k <= BUDGET; k++) begin
      if (k == restart_at) begin
        if (dut == 4) start4 = 1'b1; else start3 = 1'b1;
      end else begin
        start3 = 1'b0;
        start4 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (s_done) begin
        pulses++;
        if (lat == 0) lat = k;
      end
      if (lat != 0 && k >= lat + 4) break;
    end
    start3 = 1'b0;
    start4 = 1'b0;
    check({tag, " done_latency"}, 32'(lat), 32'(e_lat));
    check({tag, " done_pulses"},  32'(pulses), 32'd1);
    check({tag, " busy_end"},     32'(s_busy), 32'd0);
    check({tag, " pass"},         32'(s_pass), 32'(e_pass));
    check({tag, " mismatch_cnt"}, s_cnt, 32'(e_cnt));
    check({tag, " fail_valid"},   32'(s_fv), 32'(e_fv));
    if (e_fv) check({tag, " first_fail_vec"}, s_first, 32'(e_first));
    check({tag, " vec_out"},      s_vec, 32'(e_vec));
  endtask

  typedef struct {
    string tag;
    int    mode;
    logic  exp_pass;
    int    exp_cnt;
    logic  exp_fv;
    int    exp_first;
    int    exp_vec;
    int    exp_lat;
  } vec_t;

  vec_t tbl[4];
  int   mid_mode;
  int   mid_cnt;

  initial begin
    rst    = 1'b1;
    start3 = 1'b0;
    start4 = 1'b0;
    mode   = 0;
    sel    = 3;

`ifdef STOP_ON_FAIL_EN
    tbl[0] = '{"equal",     0, 1'b1, 0, 1'b0, 0, 7, 16};
    tbl[1] = '{"diff56",    1, 1'b0, 1, 1'b1, 5, 5, 12};
    tbl[2] = '{"inverted",  2, 1'b0, 1, 1'b1, 0, 0, 2};
    tbl[3] = '{"last_only", 3, 1'b0, 1, 1'b1, 7, 7, 16};
    mid_mode = 1;
    mid_cnt  = 0;
`else
    tbl[0] = '{"equal",     0, 1'b1, 0, 1'b0, 0, 7, 16};
    tbl[1] = '{"diff56",    1, 1'b0, 2, 1'b1, 5, 7, 16};
    tbl[2] = '{"inverted",  2, 1'b0, 8, 1'b1, 0, 7, 16};
    tbl[3] = '{"last_only", 3, 1'b0, 1, 1'b1, 7, 7, 16};
    mid_mode = 2;
    mid_cnt  = 3;
`endif

    // Reset state.
    #12;
    check("rst busy",         32'(busy3),  32'd0);
    check("rst done",         32'(done3),  32'd0);
    check("rst pass",         32'(pass3),  32'd0);
    check("rst vec_out",      32'(vec3),   32'd0);
    check("rst mismatch_cnt", 32'(cnt3),   32'd0);
    check("rst fail_valid",   32'(fv3),    32'd0);
    check("rst first_fail",   32'(first3), 32'd0);
    check("rst busy4",        32'(busy4),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sweeps on the 3-input instance.
    for (int i = 0; i < 4; i++) begin
      run_sweep(tbl[i].tag, 3, tbl[i].mode, tbl[i].exp_pass, tbl[i].exp_cnt,
                tbl[i].exp_fv, tbl[i].exp_first, tbl[i].exp_vec, tbl[i].exp_lat, 0);
    end

    // Start pulsed again mid-sweep is ignored.
    run_sweep("restart_ignored", 3, 0, 1'b1, 0, 1'b0, 0, 7, 16, 5);

    // Reset in the middle of a sweep.
    sel  = 3;
    mode = mid_mode;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (vec3 == 3'd3) break;
      @(posedge clk);
      #1;
    end
    check("mid vec_reached", 32'(vec3), 32'd3);
    check("mid cnt_before",  32'(cnt3), 32'(mid_cnt));
    rst = 1'b1;
    #1;
    check("mid busy",         32'(busy3), 32'd0);
    check("mid vec_out",      32'(vec3),  32'd0);
    check("mid mismatch_cnt", 32'(cnt3),  32'd0);
    check("mid fail_valid",   32'(fv3),   32'd0);
    check("mid pass",         32'(pass3), 32'd0);
    @(posedge clk);
    #1;
    check("mid no_done", 32'(done3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep("after_reset", 3, 0, 1'b1, 0, 1'b0, 0, 7, 16, 0);

    // Wide sweep: every vector mismatches, count reaches 2^N_IN without overflow.
`ifdef STOP_ON_FAIL_EN
    run_sweep("n4_inverted", 4, 2, 1'b0, 1, 1'b1, 0, 0, 4, 0);
`else
    run_sweep("n4_inverted", 4, 2, 1'b0, 16, 1'b1, 0, 15, 64, 0);
`endif
    run_sweep("n4_equal", 4, 0, 1'b1, 0, 1'b0, 0, 15, 64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
